// File: rtl/axis_adc_sampler.sv
// SAR ADC acquisition engine: CNV timing, BUSY wait, multi-lane SPI read,
// 2^n averaging and a one-deep AXI-Stream output with overflow detection.
module axis_adc_sampler #(
    parameter int NUM_SDI      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int SCK_DIV      = 2,
    parameter int CNV_HIGH     = 4,
    parameter int BUSY_TIMEOUT = 512,
    parameter int MAX_AVG_LOG2 = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  enable,
    input  logic [15:0]           cfg_period,
    input  logic [2:0]            cfg_avg_log2,
    input  logic                  status_clr,
    output logic                  cnv,
    input  logic                  busy,
    output logic                  spi_csn,
    output logic                  spi_clk_out,
    input  logic [NUM_SDI-1:0]    spi_sdi,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  overflow,
    output logic                  timeout,
    output logic                  ready
);

    localparam int BITS = DATA_WIDTH / NUM_SDI;
    localparam int BW   = $clog2(BITS) + 1;
    localparam int AW   = DATA_WIDTH + MAX_AVG_LOG2;
    localparam int CW   = MAX_AVG_LOG2 + 1;
    localparam int TW   = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNV,
        S_WAIT,
        S_READ,
        S_ACC
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                  r_busy_m;
    logic                  r_busy_s;
    logic [15:0]           r_per;
    logic                  r_first;
    logic [TW-1:0]         r_tmr;
    logic                  r_phase;
    logic [BW-1:0]         r_bit;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [AW-1:0]         r_acc;
    logic [CW-1:0]         r_cnt;
    logic [2:0]            r_neff;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_ovf;
    logic                  r_tmo;

    logic                  w_go;
    logic                  w_cnv_done;
    logic                  w_busy_ok;
    logic                  w_tmo;
    logic                  w_half_end;
    logic                  w_sample;
    logic                  w_last_bit;
    logic [2:0]            w_neff_cfg;
    logic [2:0]            w_neff;
    logic [AW-1:0]         w_acc_sum;
    logic [CW-1:0]         w_cnt_inc;
    logic                  w_blk_done;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_emit;
    logic                  w_load;

    // Period of 0 or anything shorter than the loop degenerates to back-to-back.
    assign w_go       = enable &&
                        (r_first || ({1'b0, r_per} + 17'd1 >= {1'b0, cfg_period}));
    assign w_cnv_done = r_tmr == TW'(CNV_HIGH - 1);
    assign w_busy_ok  = (r_tmr >= TW'(2)) && !r_busy_s;
    assign w_tmo      = r_tmr == TW'(BUSY_TIMEOUT - 1);
    assign w_half_end = r_tmr == TW'(SCK_DIV - 1);
    assign w_sample   = r_phase && w_half_end;
    assign w_last_bit = r_bit == BW'(BITS - 1);

    assign w_neff_cfg = (cfg_avg_log2 > 3'(MAX_AVG_LOG2)) ?
                        3'(MAX_AVG_LOG2) : cfg_avg_log2;
    assign w_neff     = (r_cnt == '0) ? w_neff_cfg : r_neff;
    assign w_acc_sum  = r_acc + {{MAX_AVG_LOG2{r_shreg[DATA_WIDTH-1]}}, r_shreg};
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_blk_done = w_cnt_inc == (CW'(1) << w_neff);
    assign w_result   = DATA_WIDTH'($signed(w_acc_sum) >>> w_neff);
    assign w_emit     = (r_state == S_ACC) && w_blk_done;
    assign w_load     = w_emit && (!r_tvalid || m_axis_tready);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_go) w_next = S_CNV;
            S_CNV:  if (w_cnv_done) w_next = S_WAIT;
            S_WAIT: if (w_busy_ok || w_tmo) w_next = S_READ;
            S_READ: if (w_sample && w_last_bit) w_next = S_ACC;
            S_ACC:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_busy_m <= 1'b0;
            r_busy_s <= 1'b0;
            r_per    <= '0;
            r_first  <= 1'b1;
            r_tmr    <= '0;
            r_phase  <= 1'b0;
            r_bit    <= '0;
            r_shreg  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neff   <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_ovf    <= 1'b0;
            r_tmo    <= 1'b0;
        end else begin
            r_busy_m <= busy;
            r_busy_s <= r_busy_m;

            if (!enable)                      r_first <= 1'b1;
            else if (r_state == S_IDLE && w_go) r_first <= 1'b0;

            if (r_state == S_IDLE && w_go) r_per <= '0;
            else if (r_per != 16'hFFFF)    r_per <= r_per + 16'd1;

            if (w_next != r_state || (r_state == S_READ && w_half_end))
                r_tmr <= '0;
            else
                r_tmr <= r_tmr + 1'b1;

            if (r_state != S_READ) r_phase <= 1'b0;
            else if (w_half_end)   r_phase <= ~r_phase;

            if (r_state != S_READ) r_bit <= '0;
            else if (w_sample)     r_bit <= r_bit + 1'b1;

            if (r_state == S_READ && w_sample)
                r_shreg <= {r_shreg[DATA_WIDTH-NUM_SDI-1:0], spi_sdi};

            // Dropping enable throws away a partially filled averaging block.
            if (r_state == S_ACC) begin
                if (r_cnt == '0) r_neff <= w_neff_cfg;
                if (w_blk_done || !enable) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_acc_sum;
                    r_cnt <= w_cnt_inc;
                end
            end else if (r_state == S_IDLE && !enable) begin
                r_acc <= '0;
                r_cnt <= '0;
            end

            if (w_load) begin
                r_tdata  <= w_result;
                r_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end

            if (w_emit && r_tvalid && !m_axis_tready) r_ovf <= 1'b1;
            else if (status_clr)                      r_ovf <= 1'b0;

            if (r_state == S_WAIT && !w_busy_ok && w_tmo) r_tmo <= 1'b1;
            else if (status_clr)                          r_tmo <= 1'b0;
        end
    end

    assign cnv           = r_state == S_CNV;
    assign spi_csn       = r_state != S_READ;
    assign spi_clk_out   = (r_state == S_READ) && r_phase;
    assign ready         = r_state == S_IDLE;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign overflow      = r_ovf;
    assign timeout       = r_tmo;

endmodule

// File: doc/axis_adc_sampler.md
Name: axis_adc_sampler

Overview:
Single-clock acquisition engine for multi-lane SPI SAR ADCs, the parametrised successor to the register-config plus data-read ADC block.
- Generates CNV at a programmable rate and tracks BUSY.
- Clocks out DATA_WIDTH bits over NUM_SDI lanes with an internally divided SCK.
- Optionally averages 2^n conversions.
- Delivers results on an AXI-Stream master with overflow detection.
- Sits between the ADC pins and the DMA/stream fabric.

Parameters:
NUM_SDI, 4, SDI lane count; must be 1, 2, 4 or 8 and divide DATA_WIDTH.
DATA_WIDTH, 32, bits per conversion, two's complement.
SCK_DIV, 2, aclk cycles per SCK half-period (>=1).
CNV_HIGH, 4, aclk cycles CNV held high.
BUSY_TIMEOUT, 512, max aclk cycles to wait for BUSY low.
MAX_AVG_LOG2, 4, largest averaging exponent.

Ports:
aclk  in  1  clock.
aresetn  in  1  synchronous active-low reset.
enable  in  1  run conversions while high.
cfg_period  in  16  conversion period in aclk cycles.
cfg_avg_log2  in  3  averaging exponent n; 2^n samples per output.
status_clr  in  1  one-cycle pulse; clears sticky flags.
cnv  out  1  ADC conversion start.
busy  in  1  ADC busy (asynchronous).
spi_csn  out  1  chip select, active low.
spi_clk_out  out  1  SCK.
spi_sdi  in  NUM_SDI  ADC data lanes.
m_axis_tdata  out  DATA_WIDTH  averaged sample.
m_axis_tvalid  out  1  sample valid.
m_axis_tready  in  1  downstream ready.
overflow  out  1  sticky: a result was dropped.
timeout  out  1  sticky: BUSY timeout occurred.
ready  out  1  FSM in IDLE.

Behaviour:
- Reset (aresetn low at aclk edge, also mid-operation): state IDLE; cnv=0, spi_csn=1, spi_clk_out=0, m_axis_tvalid=0, m_axis_tdata=0, overflow=0, timeout=0, ready=1; counters and accumulator cleared.
- busy passes through a 2-flop synchroniser; busy_s lags the pin by 2 cycles.
- Period counter: reloads to 0 on every CNV rising edge and saturates at 0xFFFF.
- FSM states: IDLE, CNV, WAIT_BUSY, READ, ACC.
- IDLE -> CNV when enable=1 and (first conversion since enable rose, or period counter >= cfg_period-1). cfg_period of 0 or smaller than the FSM loop length means back-to-back conversions with no idle cycle beyond one in IDLE.
- CNV: cnv=1 for exactly CNV_HIGH cycles, then WAIT_BUSY.
- WAIT_BUSY:
  - Ignores busy_s for the first 2 cycles (synchroniser latency).
  - Goes to READ on the first cycle busy_s=0 after that.
  - If BUSY_TIMEOUT cycles elapse, sets timeout and goes to READ anyway.
- READ:
  - spi_csn=0 and SCK runs for BITS=DATA_WIDTH/NUM_SDI periods; each period is SCK_DIV cycles low then SCK_DIV cycles high.
  - spi_sdi is sampled in the last aclk cycle of each high phase: shreg <= {shreg[DATA_WIDTH-NUM_SDI-1:0], spi_sdi}.
  - After the last bit: spi_csn=1, spi_clk_out=0, go to ACC.
- ACC:
  - n_eff = min(cfg_avg_log2, MAX_AVG_LOG2), latched at the first sample of each averaging block.
  - acc (DATA_WIDTH+MAX_AVG_LOG2 bits) += sign-extended shreg.
  - When sample count == 2^n_eff: result = (acc >>> n_eff)[DATA_WIDTH-1:0] (arithmetic shift, truncating); acc and count clear.
  - Go to IDLE.
- Output register, one deep:
  - Result written when m_axis_tvalid=0, or when m_axis_tvalid=1 and m_axis_tready=1 in the same cycle; m_axis_tvalid=1 the cycle after ACC.
  - If m_axis_tvalid=1 and m_axis_tready=0 at result time: result dropped, existing tdata held, overflow set.
  - tvalid falls on handshake unless a new result loads in that cycle.
  - tdata is stable while tvalid=1 and tready=0.
- n=0: raw word passes unchanged; latency from ACC entry to tvalid is 1 cycle.
- enable deasserted mid-conversion: current conversion and read complete; a partial averaging block is discarded (acc cleared); then the FSM stays in IDLE.
- status_clr and a flag-set event in the same cycle: set wins.
- ready=1 only in IDLE.

Test Plan:
- Raw capture: model drives 0x8BADF00D on 4 lanes, n=0, tready=1 -> one beat tdata=0x8BADF00D; spi_clk_out shows 8 periods of 2*SCK_DIV cycles.
- Lane generality: NUM_SDI=1 and 8 builds, pattern 0x0023FF42 -> tdata=0x0023FF42; SCK period count 32 and 4 respectively.
- Averaging: n=2, samples 10, 20, 30, 41 -> single beat 25; samples -4, -4, -4, -5 -> 0xFFFFFFFB (-5, arithmetic floor).
- Backpressure: tready=0 across two conversions -> first result held stable, second dropped, overflow=1; status_clr -> overflow=0.
- Period/timeout: cfg_period=200 -> CNV rising edges exactly 200 cycles apart; busy stuck high -> READ starts after 512 wait cycles, timeout=1.
- Reset mid-READ: aresetn low for one cycle during bit 3 -> spi_csn=1, spi_clk_out=0, tvalid=0 the next cycle; next conversion is correct.
